fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Frame sequencer in front of the fft core.
- Accepts a free-running real sample stream and loads exactly N = 2**N_2 samples into the core (core_load pulses). It then issues a single core_start, waits for core_done, and streams the N complex bins out with index and last markers.
- Also tracks dropped samples, completed frames and core timeouts.

Parameters:
- WIDTH, 16, real sample width; complex result width is 2*WIDTH.
- N_2, 5, log2 of FFT points; N = 2**N_2.
- TIMEOUT, 1024, max cycles from core_start to core_done before abort; must exceed core latency.
- CNT_W, 16, width of drop_cnt and frame_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; frames start only while high
- s_valid  in  1  sample present (source cannot stall)
- s_data  in  WIDTH  sample
- s_ready  out  1  sample accepted this cycle when s_valid & s_ready
- core_load  out  1  registered load strobe to core
- core_rd  out  WIDTH  registered sample to core
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  core results valid; bin k on core_wd the k-th cycle after rise (bin 0 first)
- core_wd  in  2*WIDTH  core result {re, im}
- m_valid  out  1  output bin valid
- m_data  out  2*WIDTH  bin value
- m_bin  out  N_2  bin index
- m_last  out  1  high with bin N-1
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky core timeout flag
- drop_cnt  out  CNT_W  samples dropped (s_valid & ~s_ready), saturating
- frame_cnt  out  CNT_W  frames fully emitted, wrapping

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0; sample counter, timer, bin counter, drop_cnt, frame_cnt and err_timeout cleared.
- States: IDLE, LOAD, FLUSH, START, RUN, UNLOAD.
- IDLE: s_ready = 0. Go to LOAD when en = 1.
- LOAD: s_ready = 1.
  - Each accepted sample: next cycle core_load = 1 and core_rd = s_data (latency 1); sample count +1.
  - Gaps in s_valid are allowed; core_load stays 0 during gaps.
  - On the Nth acceptance, go to FLUSH.
  - If en = 0 in LOAD: discard the partial frame, clear the count, go to IDLE. The registered load of the current-cycle sample still issues.
- FLUSH: s_ready = 0; the last core_load is visible this cycle. Go to START.
- START: core_start = 1 for exactly this cycle; timer cleared. Go to RUN.
- RUN: s_ready = 0; timer increments each cycle.
  - core_done = 1: go to UNLOAD, bin counter = 0.
  - Timer reaches TIMEOUT-1 without core_done: set err_timeout, go to IDLE.
  - err_timeout stays set until reset. The block keeps running and re-enters LOAD if en is high.
- UNLOAD: capture for N cycles starting the cycle core_done is first seen.
  - Next cycle: m_valid = 1, m_data = core_wd, m_bin = counter, m_last = (counter == N-1). m_valid lags core_done by 1 cycle.
  - core_done deasserting during UNLOAD is ignored; all N bins are emitted.
  - After the N-th capture: frame_cnt +1 (wraps). Go to LOAD if en = 1, else IDLE.
  - en falling during FLUSH, START, RUN or UNLOAD does not abort; the frame completes.
- drop_cnt: +1 each cycle with s_valid & ~s_ready in any state, including IDLE. Saturates at 2**CNT_W - 1.
- core_start is never asserted in the same cycle as core_load.
- No output backpressure: m_valid is one bin per cycle for N consecutive cycles.
- Minimum frame period: N + 3 + core latency + N cycles.

Test Plan:
- Nominal frame (en = 1, N = 32, s_data = 0..31 continuous; core model raises core_done 40 cycles after core_start, core_wd = {bin, ~bin}):
  - core_load 32 consecutive cycles starting 1 cycle after first accept.
  - core_start a single pulse 2 cycles after the 32nd accept.
  - m_valid 32 cycles, m_bin 0..31, m_last only at 31, m_data matches.
  - frame_cnt = 1, drop_cnt = 0.
- Gapped input (s_valid every 3rd cycle) → exactly 32 core_load pulses, core_rd in order, core_start only after the 32nd; then continuous s_valid in RUN for 50 cycles → drop_cnt = 50.
- Saturation: preload drop condition 70000 cycles with CNT_W = 16 → drop_cnt = 65535, no wrap.
- Timeout: core_done held 0 → err_timeout = 1 exactly TIMEOUT cycles after core_start, busy returns 0 for one cycle, then LOAD resumes; err_timeout stays 1.
- en dropped after 10 samples in LOAD → IDLE, no core_start. Re-enable → 32 fresh samples before core_start.
- Reset asserted mid-UNLOAD (at bin 12) → m_valid, busy and counters 0 immediately (asynchronous); after release, the next frame starts at m_bin 0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of an FFT core.
//   Collects N = 2**N_2 real samples from a free-running source, loads them
//   into the core, starts it, waits for core_done (with timeout) and streams
//   the N complex bins out with index and last markers.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   en                    run enable; frames start only while high
//   s_valid/s_data/s_ready  sample stream in (source cannot stall)
//   core_load/core_rd     registered load strobe and sample to the core
//   core_start            one-cycle start pulse to the core
//   core_done/core_wd     core results, bin k on the k-th cycle after rise
//   m_valid/m_data/m_bin/m_last  bin stream out, no backpressure
//   busy                  sequencer not idle
//   err_timeout           sticky core timeout flag
//   drop_cnt              saturating count of samples offered while not ready
//   frame_cnt             wrapping count of fully emitted frames
module fft_frame_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned N_2     = 5,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               s_valid,
    input  logic [WIDTH-1:0]   s_data,
    output logic               s_ready,
    output logic               core_load,
    output logic [WIDTH-1:0]   core_rd,
    output logic               core_start,
    input  logic               core_done,
    input  logic [2*WIDTH-1:0] core_wd,
    output logic               m_valid,
    output logic [2*WIDTH-1:0] m_data,
    output logic [N_2-1:0]     m_bin,
    output logic               m_last,
    output logic               busy,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   frame_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // Last sample / bin index of a frame (all ones in N_2 bits).
    localparam logic [N_2-1:0] IDX_LAST = {N_2{1'b1}};

    // Timer value one cycle before it reaches TIMEOUT-1; comparing here makes
    // err_timeout visible exactly TIMEOUT cycles after the core_start cycle.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        RUN,
        UNLOAD
    } state_t;

    state_t           state;
    logic [N_2-1:0]   samp_cnt;
    logic [N_2-1:0]   bin_cnt;
    logic [TMR_W-1:0] timer;

    // Sequencer: state, registered handshakes/strobes, counters.
    // s_ready and busy are kept as registered images of (state == LOAD) and
    // (state != IDLE), so every transition updates them together with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            core_load   <= 1'b0;
            core_rd     <= '0;
            core_start  <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_bin       <= '0;
            m_last      <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
            frame_cnt   <= '0;
            samp_cnt    <= '0;
            bin_cnt     <= '0;
            timer       <= '0;
        end else begin
            core_load  <= 1'b0;
            core_start <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;

            // Any offered sample we cannot take is lost; count it, saturating.
            if (s_valid && !s_ready && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                LOAD: begin
                    // The sample accepted this cycle is always forwarded,
                    // even when the frame is being abandoned.
                    if (s_valid) begin
                        core_load <= 1'b1;
                        core_rd   <= s_data;
                    end
                    if (!en) begin
                        samp_cnt <= '0;
                        state    <= IDLE;
                        s_ready  <= 1'b0;
                        busy     <= 1'b0;
                    end else if (s_valid) begin
                        // Wraps back to zero on the N-th acceptance.
                        samp_cnt <= samp_cnt + N_2'(1);
                        if (samp_cnt == IDX_LAST) begin
                            state   <= FLUSH;
                            s_ready <= 1'b0;
                        end
                    end
                end

                FLUSH: begin
                    // Last core_load is on the wire now; start pulse follows.
                    state      <= START;
                    core_start <= 1'b1;
                end

                START: begin
                    timer <= '0;
                    state <= RUN;
                end

                RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (core_done) begin
                        // Bin 0 is captured in the cycle core_done is seen.
                        m_valid <= 1'b1;
                        m_data  <= core_wd;
                        m_bin   <= '0;
                        bin_cnt <= N_2'(1);
                        state   <= UNLOAD;
                    end else if (timer == TMR_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end

                UNLOAD: begin
                    // core_done is not consulted: all N bins are taken.
                    m_valid <= 1'b1;
                    m_data  <= core_wd;
                    m_bin   <= bin_cnt;
                    m_last  <= (bin_cnt == IDX_LAST);
                    bin_cnt <= bin_cnt + N_2'(1);
                    if (bin_cnt == IDX_LAST) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (en) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed self-checking bench for fft_frame_ctrl with a
// small behavioural core (core_done core_lat cycles after core_start,
// core_wd = {bin, ~bin}).
module tb_fft_frame_ctrl;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned N_2     = 5;
    localparam int unsigned N       = 32;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               s_valid;
    logic [WIDTH-1:0]   s_data;
    logic               s_ready;
    logic               core_load;
    logic [WIDTH-1:0]   core_rd;
    logic               core_start;
    logic               core_done;
    logic [2*WIDTH-1:0] core_wd;
    logic               m_valid;
    logic [2*WIDTH-1:0] m_data;
    logic [N_2-1:0]     m_bin;
    logic               m_last;
    logic               busy;
    logic               err_timeout;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   frame_cnt;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .WIDTH(WIDTH), .N_2(N_2), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_load(core_load), .core_rd(core_rd), .core_start(core_start),
        .core_done(core_done), .core_wd(core_wd),
        .m_valid(m_valid), .m_data(m_data), .m_bin(m_bin), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout),
        .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural core.
    bit          core_en  = 1'b0;
    int          core_lat = 40;
    int          core_ctr;
    logic [15:0] cbin;

    always @(posedge clk or posedge reset) begin
        if (reset) core_ctr <= 0;
        else if (core_start && core_en) core_ctr <= 1;
        else if (core_ctr != 0) core_ctr <= (core_ctr >= core_lat + N - 1) ? 0 : core_ctr + 1;
    end

    always_comb begin
        cbin      = 16'(core_ctr - core_lat);
        core_done = core_en && (core_ctr != 0) && (core_ctr >= core_lat) && (core_ctr < core_lat + N);
        core_wd   = core_done ? {cbin, ~cbin} : 32'h0;
    end

    // Event log, sampled 1 time unit after each rising edge.
    int               cyc = 0;
    logic [WIDTH-1:0] ld_q[$];
    int               ld_cyc_q[$];
    int               st_cyc_q[$];
    logic [31:0]      md_q[$];
    int               mb_q[$];
    bit               ml_q[$];
    int               mc_q[$];
    int               overlap = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (core_load) begin ld_q.push_back(core_rd); ld_cyc_q.push_back(cyc); end
        if (core_start) st_cyc_q.push_back(cyc);
        if (core_start && core_load) overlap++;
        if (m_valid) begin
            md_q.push_back(m_data); mb_q.push_back(int'(m_bin));
            ml_q.push_back(m_last); mc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        ld_q.delete(); ld_cyc_q.delete(); st_cyc_q.delete();
        md_q.delete(); mb_q.delete(); ml_q.delete(); mc_q.delete();
        overlap = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
        step(); step();
        reset = 1'b0;
        clear_logs();
        step();
    endtask

    // Offer n samples (base, base+1, ...) on every gap-th cycle while ready.
    task automatic load_samples(input int n, input int base, input int gap,
                                output int first_acc, output int last_acc);
        int sent = 0;
        int k = 0;
        first_acc = -1; last_acc = -1;
        while (sent < n && k < 2000) begin
            if (s_ready && (k % gap == 0)) begin
                s_valid = 1'b1; s_data = WIDTH'(base + sent);
                if (sent == 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end else begin
                s_valid = 1'b0;
            end
            k++;
            step();
        end
        s_valid = 1'b0;
        if (sent != n) check_val("load_accept", sent, n);
    endtask

    task automatic wait_start(output int s);
        int g = 0;
        while (st_cyc_q.size() == 0 && g < 50) begin step(); g++; end
        check_val("start_seen", st_cyc_q.size(), 1);
        s = (st_cyc_q.size() > 0) ? st_cyc_q[0] : 0;
    endtask

    task automatic wait_bins(input int n);
        int g = 0;
        while (mb_q.size() < n && g < 400) begin step(); g++; end
        step(); step();
        check_val("bin_count", mb_q.size(), n);
    endtask

    // Bins must be 0..N-1 on consecutive cycles from first_cyc, last at N-1.
    function automatic int bin_errors(input int first_cyc);
        int bad = 0;
        logic [15:0] b;
        foreach (mb_q[i]) begin
            b = 16'(i);
            if (mb_q[i] != i || ml_q[i] != (i == N - 1) || md_q[i] != {b, ~b} ||
                mc_q[i] != first_cyc + i) bad++;
        end
        return bad;
    endfunction

    initial begin
        int fa, la, s, t, bad, g;

        reset = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
        step(); step();
        check_val("rst_busy", busy, 0);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_core_load", core_load, 0);
        check_val("rst_core_start", core_start, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_err", err_timeout, 0);
        check_val("rst_drop", drop_cnt, 0);
        check_val("rst_frame", frame_cnt, 0);

        // Nominal frame.
        do_reset();
        core_en = 1'b1; core_lat = 40;
        en = 1'b1; step();
        load_samples(N, 0, 1, fa, la);
        wait_start(s);
        wait_bins(N);
        check_val("nom_ld_count", ld_q.size(), N);
        check_val("nom_ld_first", ld_cyc_q[0], fa + 1);
        check_val("nom_ld_span", ld_cyc_q[N-1] - ld_cyc_q[0], N - 1);
        bad = 0;
        foreach (ld_q[i]) if (ld_q[i] != WIDTH'(i)) bad++;
        check_val("nom_ld_data", bad, 0);
        check_val("nom_start_cyc", s, la + 2);
        check_val("nom_start_count", st_cyc_q.size(), 1);
        check_val("nom_overlap", overlap, 0);
        check_val("nom_bins", bin_errors(s + 41), 0);
        check_val("nom_frame_cnt", frame_cnt, 1);
        check_val("nom_drop_cnt", drop_cnt, 0);

        // Gapped input, then drops while the core runs.
        do_reset();
        core_lat = 80;
        en = 1'b1; step();
        load_samples(N, 200, 3, fa, la);
        wait_start(s);
        check_val("gap_ld_count", ld_q.size(), N);
        bad = 0;
        foreach (ld_q[i]) if (ld_q[i] != WIDTH'(200 + i)) bad++;
        check_val("gap_ld_data", bad, 0);
        check_val("gap_start_cyc", s, la + 2);
        step();
        en = 1'b0;
        s_valid = 1'b1;
        repeat (50) step();
        s_valid = 1'b0;
        check_val("gap_drop_cnt", drop_cnt, 50);
        wait_bins(N);
        check_val("gap_bins", bin_errors(s + 81), 0);
        check_val("gap_frame_cnt", frame_cnt, 1);
        check_val("gap_idle", busy, 0);
        check_val("gap_start_count", st_cyc_q.size(), 1);

        // en dropped mid-load, then a fresh frame.
        do_reset();
        core_lat = 40;
        en = 1'b1; step();
        load_samples(10, 'h300, 1, fa, la);
        en = 1'b0; step();
        check_val("abort_busy", busy, 0);
        check_val("abort_s_ready", s_ready, 0);
        repeat (5) step();
        check_val("abort_no_start", st_cyc_q.size(), 0);
        check_val("abort_ld_count", ld_q.size(), 10);
        en = 1'b1; step();
        load_samples(N, 'h400, 1, fa, la);
        wait_start(s);
        check_val("reen_start_cyc", s, la + 2);
        check_val("reen_ld_count", ld_q.size(), 10 + N);
        bad = 0;
        for (int i = 0; i < N; i++) if (ld_q.size() > 10 + i && ld_q[10 + i] != WIDTH'('h400 + i)) bad++;
        check_val("reen_ld_data", bad, 0);
        en = 1'b0;
        wait_bins(N);
        check_val("reen_frame_cnt", frame_cnt, 1);

        // Core timeout.
        do_reset();
        core_en = 1'b0;
        en = 1'b1; step();
        load_samples(N, 0, 1, fa, la);
        wait_start(s);
        g = 0;
        while (!err_timeout && g < TIMEOUT + 20) begin step(); g++; end
        t = cyc;
        check_val("to_err_set", err_timeout, 1);
        check_val("to_delay", t - s, TIMEOUT);
        check_val("to_busy_low", busy, 0);
        step();
        check_val("to_reload_busy", busy, 1);
        check_val("to_reload_ready", s_ready, 1);
        en = 1'b0;
        repeat (3) step();
        check_val("to_err_sticky", err_timeout, 1);
        check_val("to_no_bins", mb_q.size(), 0);
        check_val("to_frame_cnt", frame_cnt, 0);

        // Asynchronous reset mid-unload.
        do_reset();
        core_en = 1'b1; core_lat = 40;
        en = 1'b1; step();
        load_samples(N, 0, 1, fa, la);
        g = 0;
        while (!(m_valid && m_bin == N_2'(12)) && g < 200) begin step(); g++; end
        check_val("mid_reached_bin12", m_bin, 12);
        #3 reset = 1'b1;
        #1;
        check_val("mid_rst_m_valid", m_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_m_bin", m_bin, 0);
        step(); step();
        reset = 1'b0;
        clear_logs();
        step();
        load_samples(N, 'h500, 1, fa, la);
        wait_start(s);
        wait_bins(N);
        check_val("post_rst_first_bin", (mb_q.size() > 0) ? mb_q[0] : -1, 0);
        check_val("post_rst_bins", bin_errors(s + 41), 0);
        check_val("post_rst_frame_cnt", frame_cnt, 1);

        // drop_cnt saturation.
        do_reset();
        en = 1'b0;
        s_valid = 1'b1;
        repeat (65534) step();
        check_val("sat_below", drop_cnt, 16'hFFFE);
        repeat (70000 - 65534) step();
        s_valid = 1'b0;
        step();
        check_val("sat_hold", drop_cnt, 16'hFFFF);
        check_val("sat_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
